// File: rtl/stage_m_mem_pkg.sv
// rtl/stage_m_mem_pkg.sv - shared M/W stage encodings, memory depth and store byte-enable helper
package stage_m_mem_pkg;

  localparam int DM_WORDS_DEFAULT = 3072;

  typedef enum logic [1:0] {
    ST_SW  = 2'b00,
    ST_SH  = 2'b01,
    ST_SB  = 2'b10,
    ST_RSV = 2'b11
  } store_type_e;

  typedef enum logic [2:0] {
    LT_LW  = 3'b000,
    LT_LH  = 3'b001,
    LT_LHU = 3'b010,
    LT_LB  = 3'b011,
    LT_LBU = 3'b100
  } load_type_e;

  typedef enum logic [1:0] {
    WDSEL_ALU = 2'b00,
    WDSEL_DM  = 2'b01,
    WDSEL_PC8 = 2'b10
  } wdsel_e;

  // Low address bits that a store type ignores are simply not looked at here.
  function automatic logic [3:0] store_be(input logic [1:0] store_type, input logic [1:0] offset);
    logic [3:0] be;
    be = 4'b0000;
    case (store_type)
      ST_SW:   be = 4'b1111;
      ST_SH:   be = offset[1] ? 4'b1100 : 4'b0011;
      ST_SB:   be = 4'b0001 << offset;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/stage_m_mem_if.sv
// rtl/stage_m_mem_if.sv - M-stage inputs and registered W-stage outputs of the memory stage
interface stage_m_mem_if;
  import stage_m_mem_pkg::*;

  logic [31:0] PC_M;
  logic [31:0] C_M;
  logic [31:0] WD_M;
  logic        MemWrite_M;
  logic [1:0]  StoreType_M;
  logic [2:0]  LoadType_M;
  logic [31:0] PC8_M;
  logic [1:0]  WDSel_M;
  logic        RegWrite_M;
  logic [4:0]  A3_M;

  logic [31:0] D_W;
  logic [31:0] C_W;
  logic [31:0] PC8_W;
  logic [1:0]  WDSel_W;
  logic        RegWrite_W;
  logic [4:0]  A3_W;

  modport master (
    output PC_M, C_M, WD_M, MemWrite_M, StoreType_M, LoadType_M,
    output PC8_M, WDSel_M, RegWrite_M, A3_M,
    input  D_W, C_W, PC8_W, WDSel_W, RegWrite_W, A3_W
  );

  modport slave (
    input  PC_M, C_M, WD_M, MemWrite_M, StoreType_M, LoadType_M,
    input  PC8_M, WDSel_M, RegWrite_M, A3_M,
    output D_W, C_W, PC8_W, WDSel_W, RegWrite_W, A3_W
  );

endinterface

// File: rtl/stage_m_mem_dm_load_ext.sv
// rtl/stage_m_mem_dm_load_ext.sv - selects and sign/zero-extends load data from the raw word
module dm_load_ext
  import stage_m_mem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  offset,
  input  logic [2:0]  load_type,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  byte_sel;

  always_comb begin
    half     = offset[1] ? raw[31:16] : raw[15:0];
    byte_sel = raw[{offset, 3'b000} +: 8];
    data     = raw;
    case (load_type)
      LT_LH:   data = {{16{half[15]}}, half};
      LT_LHU:  data = {16'h0000, half};
      LT_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LT_LBU:  data = {24'h000000, byte_sel};
      default: data = raw;
    endcase
  end

endmodule

// File: rtl/stage_m_mem.sv
// rtl/stage_m_mem.sv - memory stage: data memory, byte-enable stores, extended loads, M/W register
module stage_m_mem
  import stage_m_mem_pkg::*;
#(
  parameter int DM_WORDS = DM_WORDS_DEFAULT
) (
  input logic          clk,
  input logic          reset,
  stage_m_mem_if.slave m
);

  localparam int AW = $clog2(DM_WORDS);

  logic [31:0] dm [DM_WORDS];
  logic [29:0] word_idx;
  logic        in_range;
  logic [31:0] raw;
  logic [31:0] wdata_rep;
  logic [31:0] merged;
  logic [31:0] load_data;
  logic [3:0]  be;

  assign word_idx = m.C_M[31:2];
  assign in_range = word_idx < 30'(DM_WORDS);
  // Out-of-range words read as zero; the narrowed index is only used when in range.
  assign raw      = in_range ? dm[word_idx[AW-1:0]] : 32'h0000_0000;

  always_comb begin
    be        = store_be(m.StoreType_M, m.C_M[1:0]);
    wdata_rep = m.WD_M;
    case (m.StoreType_M)
      ST_SH:   wdata_rep = {2{m.WD_M[15:0]}};
      ST_SB:   wdata_rep = {4{m.WD_M[7:0]}};
      default: wdata_rep = m.WD_M;
    endcase
    merged = raw;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata_rep[8*i +: 8];
    end
  end

  dm_load_ext u_load_ext (
    .raw       (raw),
    .offset    (m.C_M[1:0]),
    .load_type (m.LoadType_M),
    .data      (load_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DM_WORDS; i++) dm[i] <= 32'h0000_0000;
      m.D_W        <= '0;
      m.C_W        <= '0;
      m.PC8_W      <= '0;
      m.WDSel_W    <= '0;
      m.RegWrite_W <= 1'b0;
      m.A3_W       <= '0;
    end else begin
      if (m.MemWrite_M && in_range && (be != 4'b0000)) begin
        dm[word_idx[AW-1:0]] <= merged;
      end
      m.D_W        <= load_data;
      m.C_W        <= m.C_M;
      m.PC8_W      <= m.PC8_M;
      m.WDSel_W    <= m.WDSel_M;
      m.RegWrite_W <= m.RegWrite_M;
      m.A3_W       <= m.A3_M;
    end
  end

endmodule

// File: tb/tb_stage_m_mem.sv
// tb/tb_stage_m_mem.sv - directed and randomized bench for stage_m_mem against a byte-level memory model
module tb_stage_m_mem;

  localparam int DM_WORDS = 3072;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  stage_m_mem_if bus ();

  stage_m_mem #(.DM_WORDS(DM_WORDS)) dut (
    .clk   (clk),
    .reset (reset),
    .m     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference memory is a flat little-endian byte array.
  logic [7:0] mb [4*DM_WORDS];

  function automatic bit in_mem(input logic [31:0] a);
    return (a >> 2) < DM_WORDS;
  endfunction

  function automatic logic [7:0] rd8(input logic [31:0] a);
    return in_mem(a) ? mb[a] : 8'h00;
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] a, input logic [2:0] lt);
    logic [31:0] w;
    logic [31:0] ha;
    logic [15:0] h;
    logic [7:0]  b;
    w  = {rd8({a[31:2], 2'b11}), rd8({a[31:2], 2'b10}), rd8({a[31:2], 2'b01}), rd8({a[31:2], 2'b00})};
    ha = {a[31:1], 1'b0};
    h  = {rd8(ha + 32'd1), rd8(ha)};
    b  = rd8(a);
    case (lt)
      3'd1:    return {{16{h[15]}}, h};
      3'd2:    return {16'h0, h};
      3'd3:    return {{24{b[7]}}, b};
      3'd4:    return {24'h0, b};
      default: return w;
    endcase
  endfunction

  task automatic m_store(input logic [31:0] pc, input logic [31:0] a, input logic [1:0] st, input logic [31:0] wd);
    logic [31:0] base;
    if (!in_mem(a) || st == 2'd3) return;
    case (st)
      2'd0: begin
        base = {a[31:2], 2'b00};
        for (int k = 0; k < 4; k++) mb[base + k] = wd[8*k +: 8];
      end
      2'd1: begin
        base = {a[31:1], 1'b0};
        mb[base]         = wd[7:0];
        mb[base + 32'd1] = wd[15:8];
      end
      default: mb[a] = wd[7:0];
    endcase
    $display("%d@%h: *%h <= %h", $time, pc, {a[31:2], 2'b00}, m_load({a[31:2], 2'b00}, 3'd0));
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rst, input logic [31:0] c, input logic [31:0] wd,
                      input logic mw, input logic [1:0] st, input logic [2:0] lt,
                      input logic [31:0] pc8, input logic [1:0] wdsel, input logic rw,
                      input logic [4:0] a3);
    logic [31:0] exp_d, exp_c, exp_pc8;
    logic [1:0]  exp_sel;
    logic        exp_rw;
    logic [4:0]  exp_a3;
    logic [31:0] pc;
    pc = 32'h0000_3000 + (c << 2);
    reset           = rst;
    bus.PC_M        = pc;
    bus.C_M         = c;
    bus.WD_M        = wd;
    bus.MemWrite_M  = mw;
    bus.StoreType_M = st;
    bus.LoadType_M  = lt;
    bus.PC8_M       = pc8;
    bus.WDSel_M     = wdsel;
    bus.RegWrite_M  = rw;
    bus.A3_M        = a3;
    if (rst) begin
      for (int i = 0; i < 4*DM_WORDS; i++) mb[i] = 8'h00;
      {exp_d, exp_c, exp_pc8, exp_sel, exp_rw, exp_a3} = '0;
    end else begin
      exp_d   = m_load(c, lt);
      exp_c   = c;
      exp_pc8 = pc8;
      exp_sel = wdsel;
      exp_rw  = rw;
      exp_a3  = a3;
      if (mw) m_store(pc, c, st, wd);
    end
    @(posedge clk);
    #1;
    check("D_W", bus.D_W, exp_d);
    check("C_W", bus.C_W, exp_c);
    check("PC8_W", bus.PC8_W, exp_pc8);
    check("WDSel_W", 32'(bus.WDSel_W), 32'(exp_sel));
    check("RegWrite_W", 32'(bus.RegWrite_W), 32'(exp_rw));
    check("A3_W", 32'(bus.A3_W), 32'(exp_a3));
  endtask

  initial begin
    logic [31:0] addr;
    int          mode;
    vectors     = 0;
    miscompares = 0;

    // reset, then lw of a cleared word
    step(1'b1, 32'h0, 32'hDEAD_BEEF, 1'b1, 2'd0, 3'd0, 32'h1234, 2'd1, 1'b1, 5'd7);
    step(1'b0, 32'h0, 32'h0, 1'b0, 2'd0, 3'd0, 32'h8, 2'd1, 1'b1, 5'd2);

    // word store then load
    step(1'b0, 32'h10, 32'h8765_4321, 1'b1, 2'd0, 3'd0, 32'h10, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h10, 32'h0, 1'b0, 2'd0, 3'd0, 32'h14, 2'd1, 1'b1, 5'd3);

    // byte store, then signed and unsigned byte loads
    step(1'b0, 32'h13, 32'h0000_00AB, 1'b1, 2'd2, 3'd0, 32'h18, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h10, 32'h0, 1'b0, 2'd0, 3'd0, 32'h1C, 2'd1, 1'b1, 5'd4);
    step(1'b0, 32'h13, 32'h0, 1'b0, 2'd0, 3'd3, 32'h20, 2'd1, 1'b1, 5'd5);
    step(1'b0, 32'h13, 32'h0, 1'b0, 2'd0, 3'd4, 32'h24, 2'd1, 1'b1, 5'd6);

    // half store into the upper half, then half loads
    step(1'b0, 32'h12, 32'h1234_80F0, 1'b1, 2'd1, 3'd0, 32'h28, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h12, 32'h0, 1'b0, 2'd0, 3'd1, 32'h2C, 2'd1, 1'b1, 5'd8);
    step(1'b0, 32'h12, 32'h0, 1'b0, 2'd0, 3'd2, 32'h30, 2'd1, 1'b1, 5'd9);
    step(1'b0, 32'h10, 32'h0, 1'b0, 2'd0, 3'd1, 32'h34, 2'd1, 1'b1, 5'd10);

    // store at index == DM_WORDS is dropped and reads back as zero
    step(1'b0, 32'h3000, 32'hFFFF_FFFF, 1'b1, 2'd0, 3'd0, 32'h38, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h3000, 32'h0, 1'b0, 2'd0, 3'd0, 32'h3C, 2'd1, 1'b1, 5'd11);
    step(1'b0, 32'h2FFC, 32'hCAFE_F00D, 1'b1, 2'd0, 3'd0, 32'h40, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h2FFE, 32'h0, 1'b0, 2'd0, 3'd1, 32'h44, 2'd1, 1'b1, 5'd12);

    // reset wins over a simultaneous store; pass-through of link values
    step(1'b1, 32'h20, 32'h5555_AAAA, 1'b1, 2'd0, 3'd0, 32'h0, 2'd0, 1'b0, 5'd0);
    step(1'b0, 32'h20, 32'h0, 1'b0, 2'd0, 3'd0, 32'h3008, 2'd2, 1'b1, 5'd31);
    step(1'b0, 32'h10, 32'h0, 1'b0, 2'd0, 3'd0, 32'h300C, 2'd0, 1'b0, 5'd1);

    // randomized traffic over a small window plus the top and out-of-range edge
    for (int n = 0; n < 300; n++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0)      addr = 32'h3000 + $urandom_range(0, 15);
      else if (mode == 1) addr = 32'h2FF0 + $urandom_range(0, 15);
      else                addr = $urandom_range(0, 63);
      step(($urandom_range(0, 79) == 0), addr, $urandom, 1'($urandom), 2'($urandom_range(0, 3)),
           3'($urandom_range(0, 7)), $urandom, 2'($urandom_range(0, 3)), 1'($urandom), 5'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
